// File: rtl/gpr_sb.sv
// General-purpose register file with a per-register busy scoreboard.
// Two writeback ports (A older, B younger), same-cycle read bypass, and a running count of busy registers.
module gpr_sb #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    localparam int AW  = $clog2(NREG)
) (
    input  logic            I_sys_clk,
    input  logic            I_rst,
    input  logic            I_wa_en,
    input  logic [AW-1:0]   I_wa_addr,
    input  logic [XLEN-1:0] I_wa_data,
    input  logic            I_wb_en,
    input  logic [AW-1:0]   I_wb_addr,
    input  logic [XLEN-1:0] I_wb_data,
    input  logic            I_iss_en,
    input  logic [AW-1:0]   I_iss_rd,
    input  logic            I_flush,
    input  logic [AW-1:0]   I_rs1_addr,
    input  logic [AW-1:0]   I_rs2_addr,
    output logic [XLEN-1:0] O_rs1_data,
    output logic [XLEN-1:0] O_rs2_data,
    output logic            O_rs1_busy,
    output logic            O_rs2_busy,
    output logic [AW:0]     O_busy_cnt
);

    logic [XLEN-1:0] r_regs [NREG];
    logic [NREG-1:0] r_busy;
    logic [AW:0]     r_busy_cnt;

    logic            w_wa_act;
    logic            w_wb_act;
    logic            w_iss_set;
    logic [NREG-1:0] w_busy_nxt;
    logic            w_inc;
    logic            w_dec_a;
    logic            w_dec_b;
    logic [AW:0]     w_cnt_nxt;

    assign w_wa_act  = I_wa_en  && (I_wa_addr != '0);
    assign w_wb_act  = I_wb_en  && (I_wb_addr != '0);
    assign w_iss_set = I_iss_en && (I_iss_rd  != '0);

    // Bypass order: port B (younger) beats port A beats storage; x0 beats everything.
    function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] addr);
        if (addr == '0)
            return '0;
        else if (I_wb_en && (I_wb_addr == addr))
            return I_wb_data;
        else if (I_wa_en && (I_wa_addr == addr))
            return I_wa_data;
        else
            return r_regs[addr];
    endfunction

    function automatic logic read_busy(input logic [AW-1:0] addr);
        return (addr != '0) && r_busy[addr]
            && !(I_wa_en && (I_wa_addr == addr))
            && !(I_wb_en && (I_wb_addr == addr));
    endfunction

    always_comb begin
        O_rs1_data = read_port(I_rs1_addr);
        O_rs2_data = read_port(I_rs2_addr);
        O_rs1_busy = read_busy(I_rs1_addr);
        O_rs2_busy = read_busy(I_rs2_addr);
    end

    // Writeback clears, issue sets afterwards so it wins, flush overrides both.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wa_act)
            w_busy_nxt[I_wa_addr] = 1'b0;
        if (w_wb_act)
            w_busy_nxt[I_wb_addr] = 1'b0;
        if (w_iss_set)
            w_busy_nxt[I_iss_rd] = 1'b1;
        if (I_flush)
            w_busy_nxt = '0;
        w_busy_nxt[0] = 1'b0;
    end

    // Incremental count; a port clearing a bit that issue re-sets, or that port A already cleared, does not count.
    always_comb begin
        w_inc   = w_iss_set && !r_busy[I_iss_rd];
        w_dec_a = w_wa_act && r_busy[I_wa_addr]
                  && !(w_iss_set && (I_iss_rd == I_wa_addr));
        w_dec_b = w_wb_act && r_busy[I_wb_addr]
                  && !(w_iss_set && (I_iss_rd == I_wb_addr))
                  && !(w_wa_act && (I_wa_addr == I_wb_addr));
        if (I_flush)
            w_cnt_nxt = '0;
        else
            w_cnt_nxt = r_busy_cnt + (AW+1)'(w_inc) - (AW+1)'(w_dec_a) - (AW+1)'(w_dec_b);
    end

    always_ff @(posedge I_sys_clk) begin
        if (I_rst) begin
            for (int i = 0; i < NREG; i++)
                r_regs[i] <= '0;
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            if (w_wa_act)
                r_regs[I_wa_addr] <= I_wa_data;
            if (w_wb_act)
                r_regs[I_wb_addr] <= I_wb_data;
            r_busy     <= w_busy_nxt;
            r_busy_cnt <= w_cnt_nxt;
        end
    end

    assign O_busy_cnt = r_busy_cnt;

endmodule

// File: tb/tb_gpr_sb.sv
// Self-checking bench for gpr_sb: directed scenarios then randomized traffic,
// all checked against an array-based reference model of registers and busy set.
module tb_gpr_sb;

    localparam int XLEN = 32;
    localparam int NREG = 16;
    localparam int AW   = $clog2(NREG);

    logic            clk;
    logic            rst;
    logic            wa_en, wb_en, iss_en, flush;
    logic [AW-1:0]   wa_addr, wb_addr, iss_rd, rs1_addr, rs2_addr;
    logic [XLEN-1:0] wa_data, wb_data;
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic            rs1_busy, rs2_busy;
    logic [AW:0]     busy_cnt;

    logic [XLEN-1:0] m_regs [NREG];
    bit              m_busy [NREG];

    int n_vec;
    int n_err;

    gpr_sb #(.XLEN(XLEN), .NREG(NREG)) u_dut (
        .I_sys_clk (clk),
        .I_rst     (rst),
        .I_wa_en   (wa_en),
        .I_wa_addr (wa_addr),
        .I_wa_data (wa_data),
        .I_wb_en   (wb_en),
        .I_wb_addr (wb_addr),
        .I_wb_data (wb_data),
        .I_iss_en  (iss_en),
        .I_iss_rd  (iss_rd),
        .I_flush   (flush),
        .I_rs1_addr(rs1_addr),
        .I_rs2_addr(rs2_addr),
        .O_rs1_data(rs1_data),
        .O_rs2_data(rs2_data),
        .O_rs1_busy(rs1_busy),
        .O_rs2_busy(rs2_busy),
        .O_busy_cnt(busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [XLEN-1:0] m_read(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (wb_en && wb_addr == a) return wb_data;
        if (wa_en && wa_addr == a) return wa_data;
        return m_regs[a];
    endfunction

    function automatic logic m_rbusy(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
        if (wa_en && wa_addr == a) return 1'b0;
        if (wb_en && wb_addr == a) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int r = 0; r < NREG; r++) c += int'(m_busy[r]);
        return c;
    endfunction

    task automatic m_update();
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                m_regs[r] = '0;
                m_busy[r] = 1'b0;
            end
        end else begin
            if (wa_en && wa_addr != 0) m_regs[wa_addr] = wa_data;
            if (wb_en && wb_addr != 0) m_regs[wb_addr] = wb_data;
            for (int r = 1; r < NREG; r++) begin
                bit nb = m_busy[r];
                if ((wa_en && wa_addr == r) || (wb_en && wb_addr == r)) nb = 1'b0;
                if (iss_en && iss_rd == r) nb = 1'b1;
                if (flush) nb = 1'b0;
                m_busy[r] = nb;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle();
        rst = 0; wa_en = 0; wb_en = 0; iss_en = 0; flush = 0;
        wa_addr = '0; wb_addr = '0; iss_rd = '0; rs1_addr = '0; rs2_addr = '0;
        wa_data = '0; wb_data = '0;
    endtask

    // Inputs are driven after the falling edge; outputs compared 2 time units later.
    task automatic settle();
        #2;
        check("rs1_data", 64'(rs1_data), 64'(m_read(rs1_addr)));
        check("rs2_data", 64'(rs2_data), 64'(m_read(rs2_addr)));
        check("rs1_busy", 64'(rs1_busy), 64'(m_rbusy(rs1_addr)));
        check("rs2_busy", 64'(rs2_busy), 64'(m_rbusy(rs2_addr)));
        check("busy_cnt", 64'(busy_cnt), 64'(m_count()));
    endtask

    task automatic tick();
        @(posedge clk);
        m_update();
        @(negedge clk);
    endtask

    task automatic step();
        settle();
        tick();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        for (int r = 0; r < NREG; r++) begin
            m_regs[r] = '0;
            m_busy[r] = 1'b0;
        end
        idle();
        rst = 1;
        @(negedge clk);
        tick();
        tick();
        idle();
        settle();
        check("reset_cnt", 64'(busy_cnt), 64'd0);
        check("reset_rs1", 64'(rs1_data), 64'd0);

        // write then read back
        wa_en = 1; wa_addr = 5; wa_data = 32'h1234;
        step();
        idle(); rs1_addr = 5;
        settle();
        check("x5_data", 64'(rs1_data), 64'h1234);
        check("x5_busy", 64'(rs1_busy), 64'd0);
        tick();

        // dual write, B wins and is bypassed
        wa_en = 1; wa_addr = 7; wa_data = 32'hAAAA;
        wb_en = 1; wb_addr = 7; wb_data = 32'hBBBB; rs2_addr = 7;
        settle();
        check("x7_bypass", 64'(rs2_data), 64'hBBBB);
        tick();
        idle(); rs2_addr = 7;
        settle();
        check("x7_stored", 64'(rs2_data), 64'hBBBB);
        tick();

        // issue then writeback
        iss_en = 1; iss_rd = 3;
        step();
        idle(); rs1_addr = 3;
        settle();
        check("x3_busy", 64'(rs1_busy), 64'd1);
        check("x3_cnt1", 64'(busy_cnt), 64'd1);
        wb_en = 1; wb_addr = 3; wb_data = 32'h55;
        settle();
        check("x3_wb_busy", 64'(rs1_busy), 64'd0);
        check("x3_wb_data", 64'(rs1_data), 64'h55);
        tick();
        idle();
        settle();
        check("x3_cnt0", 64'(busy_cnt), 64'd0);

        // issue and writeback same reg; issue x0
        iss_en = 1; iss_rd = 9; wa_en = 1; wa_addr = 9; wa_data = 32'h99;
        step();
        idle(); rs1_addr = 9;
        settle();
        check("x9_busy", 64'(rs1_busy), 64'd1);
        check("x9_cnt", 64'(busy_cnt), 64'd1);
        iss_en = 1; iss_rd = 0;
        step();
        idle(); rs1_addr = 0;
        settle();
        check("x0_busy", 64'(rs1_busy), 64'd0);
        check("x0_cnt", 64'(busy_cnt), 64'd1);
        wa_en = 1; wa_addr = 9; wa_data = 32'h9;
        step();
        idle();

        // three issues then flush with issue and write to x6
        iss_en = 1; iss_rd = 1; step();
        iss_rd = 2; step();
        iss_rd = 4; step();
        idle();
        settle();
        check("cnt3", 64'(busy_cnt), 64'd3);
        flush = 1; iss_en = 1; iss_rd = 6; wa_en = 1; wa_addr = 6; wa_data = 32'h66;
        step();
        idle(); rs1_addr = 6; rs2_addr = 1;
        settle();
        check("flush_cnt", 64'(busy_cnt), 64'd0);
        check("flush_x6_busy", 64'(rs1_busy), 64'd0);
        check("flush_x6_data", 64'(rs1_data), 64'h66);
        check("flush_x1_busy", 64'(rs2_busy), 64'd0);
        tick();

        // fill every register busy, then reset
        for (int r = 1; r < NREG; r++) begin
            idle(); iss_en = 1; iss_rd = AW'(r);
            step();
        end
        idle();
        settle();
        check("full_cnt", 64'(busy_cnt), 64'(NREG - 1));
        rst = 1; wa_en = 1; wa_addr = 2; wa_data = 32'hDEAD; iss_en = 1; iss_rd = 3;
        step();
        idle();
        settle();
        check("rst_cnt", 64'(busy_cnt), 64'd0);
        for (int r = 0; r < NREG; r++) begin
            rs1_addr = AW'(r); rs2_addr = AW'(NREG - 1 - r);
            settle();
            check("rst_read", 64'(rs1_data), 64'd0);
        end
        tick();

        // randomized traffic, addresses biased low to force collisions
        for (int n = 0; n < 600; n++) begin
            int span;
            span     = ($urandom_range(0, 1) == 0) ? 3 : NREG - 1;
            rst      = ($urandom_range(0, 149) == 0);
            flush    = ($urandom_range(0, 24) == 0);
            iss_en   = ($urandom_range(0, 1) == 0);
            wa_en    = ($urandom_range(0, 2) == 0);
            wb_en    = ($urandom_range(0, 2) == 0);
            iss_rd   = AW'($urandom_range(0, span));
            wa_addr  = AW'($urandom_range(0, span));
            wb_addr  = AW'($urandom_range(0, span));
            rs1_addr = AW'($urandom_range(0, span));
            rs2_addr = AW'($urandom_range(0, span));
            wa_data  = XLEN'($urandom);
            wb_data  = XLEN'($urandom);
            step();
        end
        idle();
        settle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gpr_sb.md
GPR_SB -- requirements
Module: ysyx_22040750_gpr_sb

Interface
REQ-001 Parameter XLEN, default 64, register data width in bits.
REQ-002 Parameter NREG, default 32, number of architectural registers; power of two, 2..64.
REQ-003 Local parameter AW = log2(NREG), register address width.
REQ-004 I_sys_clk  input  1  clock; all state updates on its rising edge.
REQ-005 I_rst  input  1  reset, synchronous, active-high.
REQ-006 I_wa_en / I_wa_addr / I_wa_data  input  1 / AW / XLEN  writeback port A (older instruction).
REQ-007 I_wb_en / I_wb_addr / I_wb_data  input  1 / AW / XLEN  writeback port B (younger instruction).
REQ-008 I_iss_en / I_iss_rd  input  1 / AW  issue: mark destination register busy.
REQ-009 I_flush  input  1  clear all busy bits.
REQ-010 I_rs1_addr, I_rs2_addr  input  AW each  read addresses.
REQ-011 O_rs1_data, O_rs2_data  output  XLEN each  read data (combinational).
REQ-012 O_rs1_busy, O_rs2_busy  output  1 each  source operand not yet available.
REQ-013 O_busy_cnt  output  AW+1  number of registers currently marked busy.

Function
REQ-014 Register 0 SHALL always read 0, SHALL ignore writes, and SHALL never become busy.
REQ-015 A write on an enabled port SHALL update the addressed register at the next rising edge.
REQ-016 Same-cycle writes from A and B to the same nonzero address SHALL leave port B data.
REQ-017 Read data SHALL bypass same-cycle writes: on address match with enabled port B, return I_wb_data; else on match with port A, return I_wa_data; else return the stored value.
REQ-018 The register-0 rule (REQ-014) SHALL override bypass.
REQ-019 Busy bit r SHALL set at the next edge when I_iss_en=1 and I_iss_rd=r (r≠0).
REQ-020 Busy bit r SHALL clear at the next edge when either write port is enabled with address r.
REQ-021 Issue and writeback to the same r in the same cycle: set wins; bit ends 1.
REQ-022 I_flush=1 SHALL clear every busy bit at the next edge, overriding same-cycle issue.
REQ-023 Flush SHALL NOT block same-cycle register writes.
REQ-024 O_rsN_busy SHALL equal busy[rsN] AND NOT (any enabled write port addressing rsN this cycle); it SHALL always be 0 for address 0.
REQ-025 O_busy_cnt SHALL be a registered counter equal to the popcount of busy bits after each edge; it SHALL be updated incrementally (+1 on a set of a clear bit, -1 per cleared set bit, net of both) and SHALL never exceed NREG-1.
REQ-026 Writeback to a non-busy register SHALL write data and leave busy state and count unchanged.

Reset
REQ-027 While I_rst=1 at an edge, all registers SHALL be 0, all busy bits 0, and O_busy_cnt 0; reset SHALL override writes, issue and flush.
REQ-028 Reset asserted mid-operation SHALL discard outstanding busy state; the first post-reset cycle SHALL read all registers as 0 with no busy.

Verification
REQ-029 Reset, then write A x5=0x1234 -> next cycle rs1=x5 reads 0x1234, busy 0.
REQ-030 Same cycle: A x7=0xAAAA, B x7=0xBBBB, rs2=x7 -> same-cycle O_rs2_data=0xBBBB; stored value 0xBBBB.
REQ-031 Issue x3 -> rs1=x3 busy=1, cnt=1; next cycle B writes x3=0x55 -> same-cycle busy=0, data=0x55; afterwards cnt=0.
REQ-032 Issue x9 while A writes x9 -> x9 busy=1, cnt unchanged at +1; issue x0 -> no busy, cnt unchanged.
REQ-033 Issue x1, x2, x4 over 3 cycles (cnt=3), then flush with issue x6 -> all busy 0, cnt=0; a same-cycle write to x6 lands.
REQ-034 NREG=16, XLEN=32: fill x1..x15 busy -> cnt=15; assert I_rst -> cnt=0, all reads 0.
